// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: operand/operation sequencer for the switch calculator.
// Captures operand 1, the operation and operand 2 from edge-detected buttons,
// issues a one-cycle start pulse, waits for op_done (with a timeout guard)
// and flags the display mux to show the result or the error.
// Optional macro CALC_AUTO_CLEAR_EN: RESULT returns to ENTER_A after
// DISPLAY_HOLD cycles without a select press.
module calc_op_sequencer #(
    parameter int WIDTH        = 16,
    parameter int TIMEOUT      = 64,
    parameter int DISPLAY_HOLD = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bit_input,
    input  logic             b_up_add_out,
    input  logic             b_left_subtract_out,
    input  logic             b_right_multiply_out,
    input  logic             b_down_square_out,
    input  logic             b_mid_select_out,
    input  logic             op_done,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic [1:0]       opcode,
    output logic             op_start,
    output logic             operation_state,
    output logic             err,
    output logic [2:0]       fsm_state
);

    localparam int TO_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_OP = 3'd1,
        ENTER_B  = 3'd2,
        COMPUTE  = 3'd3,
        RESULT   = 3'd4,
        ERR      = 3'd5
    } state_t;

    // Opcode values as seen by the operator output mux
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_SQR = 2'd3;

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    logic prev_add, prev_sub, prev_mul, prev_sqr, prev_sel;
    logic press_add, press_sub, press_mul, press_sqr, press_sel;
    logic press_op;

`ifdef CALC_AUTO_CLEAR_EN
    localparam int HOLD_W = $clog2(DISPLAY_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;
`else
    logic hold_param_unused;
    assign hold_param_unused = (DISPLAY_HOLD != 0);
`endif

    assign press_add = b_up_add_out         & ~prev_add;
    assign press_sub = b_left_subtract_out  & ~prev_sub;
    assign press_mul = b_right_multiply_out & ~prev_mul;
    assign press_sqr = b_down_square_out    & ~prev_sqr;
    assign press_sel = b_mid_select_out     & ~prev_sel;
    assign press_op  = press_add | press_sub | press_mul | press_sqr;

    assign fsm_state = state;

    // Button history; reset high so a button held through reset gives no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_add <= 1'b1;
            prev_sub <= 1'b1;
            prev_mul <= 1'b1;
            prev_sqr <= 1'b1;
            prev_sel <= 1'b1;
        end else begin
            prev_add <= b_up_add_out;
            prev_sub <= b_left_subtract_out;
            prev_mul <= b_right_multiply_out;
            prev_sqr <= b_down_square_out;
            prev_sel <= b_mid_select_out;
        end
    end

    // Sequencer FSM with registered outputs and timeout/hold counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ENTER_A;
            input1          <= '0;
            input2          <= '0;
            opcode          <= OP_ADD;
            op_start        <= 1'b0;
            operation_state <= 1'b0;
            err             <= 1'b0;
            to_cnt          <= '0;
`ifdef CALC_AUTO_CLEAR_EN
            hold_cnt        <= '0;
`endif
        end else begin
            case (state)
                ENTER_A: begin
                    if (press_sel) begin
                        input1 <= bit_input;
                        state  <= ENTER_OP;
                    end
                end

                ENTER_OP: begin
                    if (press_op) begin
                        if (press_add) begin
                            opcode <= OP_ADD;
                            state  <= ENTER_B;
                        end else if (press_sub) begin
                            opcode <= OP_SUB;
                            state  <= ENTER_B;
                        end else if (press_mul) begin
                            opcode <= OP_MUL;
                            state  <= ENTER_B;
                        end else begin
                            opcode   <= OP_SQR;
                            input2   <= input1;
                            op_start <= 1'b1;
                            to_cnt   <= '0;
                            state    <= COMPUTE;
                        end
                    end
                end

                ENTER_B: begin
                    if (press_sel) begin
                        input2   <= bit_input;
                        op_start <= 1'b1;
                        to_cnt   <= '0;
                        state    <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    // op_start high marks the first cycle; op_done is ignored there
                    op_start <= 1'b0;
                    if (op_done && !op_start) begin
                        to_cnt          <= '0;
                        operation_state <= 1'b1;
                        state           <= RESULT;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        to_cnt          <= '0;
                        err             <= 1'b1;
                        operation_state <= 1'b1;
                        state           <= ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RESULT: begin
                    if (press_sel) begin
                        operation_state <= 1'b0;
                        state           <= ENTER_A;
`ifdef CALC_AUTO_CLEAR_EN
                        hold_cnt        <= '0;
                    end else if (hold_cnt == HOLD_W'(DISPLAY_HOLD - 1)) begin
                        hold_cnt        <= '0;
                        operation_state <= 1'b0;
                        state           <= ENTER_A;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end

                ERR: begin
                    if (press_sel) begin
                        err             <= 1'b0;
                        operation_state <= 1'b0;
                        state           <= ENTER_A;
                    end
                end

                default: begin
                    op_start        <= 1'b0;
                    err             <= 1'b0;
                    operation_state <= 1'b0;
                    to_cnt          <= '0;
                    state           <= ENTER_A;
                end
            endcase
        end
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Operand/operation sequencer for the switch-driven calculator. It takes debounced button levels and the 16-bit switch word, and captures operand 1, the operation and operand 2 in order. It then issues a single start pulse to the selected operation unit, waits for its done strobe, and flags the display-path mux to show the result. It replaces the free-running store/opcode logic with a deterministic FSM, a timeout guard and an error state.

Parameters:
WIDTH, 16, operand width; equals switch width
TIMEOUT, 64, max cycles to wait for op_done after op_start before entering ERR
DISPLAY_HOLD, 100000000, result display cycles before auto-clear (used only with CALC_AUTO_CLEAR_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
bit_input  in  WIDTH  switch word
b_up_add_out  in  1  debounced add button level
b_left_subtract_out  in  1  debounced subtract button level
b_right_multiply_out  in  1  debounced multiply button level
b_down_square_out  in  1  debounced square button level
b_mid_select_out  in  1  debounced select button level
op_done  in  1  operation unit completion strobe
input1  out  WIDTH  latched operand 1
input2  out  WIDTH  latched operand 2
opcode  out  2  0=add 1=multiply 2=subtract 3=square (matches operator output mux)
op_start  out  1  one-cycle start pulse to operation unit
operation_state  out  1  0=show switches, 1=show result/error
err  out  1  timeout error flag
fsm_state  out  3  current state encoding, for debug LEDs

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset values: input1=0, input2=0, opcode=0, op_start=0, operation_state=0, err=0, state=ENTER_A, timeout counter=0.
- Button history registers reset to 1. A button held through reset release produces no edge.
- Edge detect: press = level & ~prev. prev updates every cycle. All FSM decisions use press, never level.
- Op-button priority on simultaneous presses: add > subtract > multiply > square.
- States and encodings: ENTER_A=0, ENTER_OP=1, ENTER_B=2, COMPUTE=3, RESULT=4, ERR=5.
- ENTER_A: select press latches input1<=bit_input, next ENTER_OP. Op presses are ignored.
- ENTER_OP: an op press latches opcode.
  - Square: input2<=input1, next COMPUTE.
  - Any other op: next ENTER_B.
  - Select presses are ignored.
- ENTER_B: select press latches input2<=bit_input, next COMPUTE. Op presses are ignored; opcode cannot change.
- COMPUTE:
  - op_start=1 in the first COMPUTE cycle only. It is registered and high for exactly one cycle.
  - op_done is sampled from the cycle after op_start. op_done coincident with op_start is ignored.
  - op_done=1 -> RESULT on the next edge.
  - The counter increments each waiting cycle. Counter reaching TIMEOUT-1 without op_done -> ERR.
  - op_done and timeout in the same cycle: op_done wins.
  - Buttons are ignored in COMPUTE.
- RESULT: operation_state=1. Select press -> ENTER_A; operands and opcode are retained until overwritten.
- ERR: err=1, operation_state=1. Select press clears err -> ENTER_A.
- operation_state=0 in ENTER_A, ENTER_OP, ENTER_B and COMPUTE.
- operation_state, err and op_start are registered outputs, so there are no glitches into the display mux.
- rst asserted mid-operation (any state, including during op_start) immediately forces all reset values. No pending start survives.
- Widths: the timeout counter is clog2(TIMEOUT)+1 bits; the hold counter is sized to DISPLAY_HOLD. Neither counter wraps: both clear on state exit.

Optional Feature:
CALC_AUTO_CLEAR_EN
- Defined: RESULT also counts cycles. After DISPLAY_HOLD cycles without a select press, the FSM returns to ENTER_A with operation_state=0.
  - A select press before expiry behaves as normal.
  - ERR never auto-clears.
- Undefined: RESULT holds indefinitely. The hold counter and DISPLAY_HOLD are unused and no hold logic is synthesised.

Test Plan:
- Add flow: sw=0x0012, select; add press; sw=0x0034, select; op_done 3 cycles after op_start -> input1=0x0012, input2=0x0034, opcode=0, op_start high exactly 1 cycle, operation_state=1 one cycle after op_done.
- Square shortcut: sw=0x0009, select, square press -> ENTER_B skipped, input2=0x0009, opcode=3, op_start asserted the next cycle.
- Simultaneous press: add and multiply rising together in ENTER_OP -> opcode=0. Select pressed in ENTER_OP -> state stays 1.
- Timeout: TIMEOUT=8, op_done held 0 -> ERR after 8 COMPUTE cycles, err=1, operation_state=1; select -> ENTER_A, err=0.
- Reset robustness: select held across rst deassert -> no capture. rst pulsed during COMPUTE -> all outputs at reset values in the same cycle, state=0.
- With CALC_AUTO_CLEAR_EN, DISPLAY_HOLD=10: idle in RESULT -> ENTER_A after 10 cycles. Without the macro -> still RESULT after 1000 cycles.
